// File: rtl/zoom_pkg.sv
// zoom_pkg: shared encodings for the zoom engine and its selection side.
`default_nettype none

package zoom_pkg;

  localparam logic [1:0] ALG_NN = 2'd0;
  localparam logic [1:0] ALG_PR = 2'd1;
  localparam logic [1:0] ALG_DC = 2'd2;
  localparam logic [1:0] ALG_BA = 2'd3;

  localparam logic [1:0] ST_DEFAULT  = 2'd0;
  localparam logic [1:0] ST_ENLARGED = 2'd1;
  localparam logic [1:0] ST_REDUCED  = 2'd2;

  typedef enum logic [2:0] {
    MODE_COPY = 3'd0,
    MODE_NN   = 3'd1,
    MODE_PR   = 3'd2,
    MODE_DC   = 3'd3,
    MODE_BA   = 3'd4
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WR     = 3'd2,
    S_PR_WR  = 3'd3,
    S_BA_RD  = 3'd4,
    S_BA_ACC = 3'd5,
    S_BA_WR  = 3'd6,
    S_FIN    = 3'd7
  } state_t;

  // Unsupported scale codes fall back to a plain copy.
  function automatic mode_t resolve_mode(input logic [1:0] alg, input logic [1:0] st);
    mode_t m;
    m = MODE_COPY;
    case (st)
      ST_DEFAULT:  m = MODE_COPY;
      ST_ENLARGED: m = (alg == ALG_PR) ? MODE_PR : MODE_NN;
      ST_REDUCED:  m = (alg == ALG_DC || alg == ALG_NN || alg == ALG_PR) ? MODE_DC : MODE_BA;
      default:     m = MODE_COPY;
    endcase
    return m;
  endfunction

  function automatic logic [9:0] scaled_dim(input mode_t m, input logic [9:0] n);
    logic [9:0] d;
    d = n;
    case (m)
      MODE_NN, MODE_PR: d = n << 1;
      MODE_DC, MODE_BA: d = n >> 1;
      default:          d = n;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/zoom_xy_counter.sv
// zoom_xy_counter: row-major x/y counter with run-time limits and last-position flag.
`default_nettype none

module zoom_xy_counter #(
  parameter int XW = 10,
  parameter int YW = 10
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          i_clr,
  input  logic          i_inc,
  input  logic [XW-1:0] i_x_max,
  input  logic [YW-1:0] i_y_max,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_last
);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_inc) begin
      if (r_x == i_x_max) begin
        r_x <= '0;
        r_y <= (r_y == i_y_max) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = (r_x == i_x_max) && (r_y == i_y_max);

endmodule

`default_nettype wire

// File: rtl/zoom_engine.sv
// zoom_engine: streams a source image through COPY/NN/PR/DC/BA scaling into
// a compact row-major destination frame buffer.
`default_nettype none

module zoom_engine
  import zoom_pkg::*;
#(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int PIX_W  = 8,
  parameter int SRC_AW = 15,
  parameter int DST_AW = 17
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [1:0]        ALGORITHM,
  input  logic [1:0]        IMAGE_STATE,
  output logic              SRC_RD_EN,
  output logic [SRC_AW-1:0] SRC_ADDR,
  input  logic [PIX_W-1:0]  SRC_DATA,
  output logic              DST_WE,
  output logic [DST_AW-1:0] DST_ADDR,
  output logic [PIX_W-1:0]  DST_DATA,
  output logic [9:0]        OUT_W,
  output logic [9:0]        OUT_H,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [9:0] c_W = 10'(SRC_W);
  localparam logic [9:0] c_H = 10'(SRC_H);

  state_t             r_state, w_next;
  mode_t              r_mode, w_start_mode, w_grid_mode;
  logic [9:0]         r_out_w, r_out_h;
  logic [PIX_W-1:0]   r_pix;
  logic [PIX_W+1:0]   r_acc;
  logic               w_accept, w_c_clr, w_c_inc, w_s_inc;
  logic [9:0]         w_cx, w_cy, w_xmax, w_ymax;
  logic [9:0]         w_sx, w_sy, w_dx, w_dy;
  logic               w_bx, w_by, w_c_last, w_s_last, w_sub_first;
  logic [SRC_AW-1:0]  w_src_addr;
  logic [DST_AW-1:0]  w_dst_addr;
  logic [PIX_W-1:0]   w_dst_data, w_avg;

  assign w_start_mode = resolve_mode(ALGORITHM, IMAGE_STATE);
  // PR walks the source grid; every other mode walks the destination grid.
  assign w_grid_mode  = (r_mode == MODE_PR) ? MODE_COPY : r_mode;
  assign w_xmax       = scaled_dim(w_grid_mode, c_W) - 10'd1;
  assign w_ymax       = scaled_dim(w_grid_mode, c_H) - 10'd1;
  assign w_sub_first  = !w_bx && !w_by;

  zoom_xy_counter #(.XW(10), .YW(10)) u_pix_cnt (
    .CLK(CLK), .RESET(RESET), .i_clr(w_c_clr), .i_inc(w_c_inc),
    .i_x_max(w_xmax), .i_y_max(w_ymax),
    .o_x(w_cx), .o_y(w_cy), .o_last(w_c_last)
  );

  zoom_xy_counter #(.XW(1), .YW(1)) u_sub_cnt (
    .CLK(CLK), .RESET(RESET), .i_clr(w_c_clr), .i_inc(w_s_inc),
    .i_x_max(1'b1), .i_y_max(1'b1),
    .o_x(w_bx), .o_y(w_by), .o_last(w_s_last)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_COPY;
      r_out_w <= '0;
      r_out_h <= '0;
      r_pix   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mode  <= w_start_mode;
        r_out_w <= scaled_dim(w_start_mode, c_W);
        r_out_h <= scaled_dim(w_start_mode, c_H);
      end
      if (r_state == S_PR_WR && w_sub_first) r_pix <= SRC_DATA;
      // Read data trails the BA read strobe by a cycle, so the first beat only clears.
      if (r_state == S_BA_RD && w_sub_first) r_acc <= '0;
      else if (r_state == S_BA_RD || r_state == S_BA_ACC) r_acc <= r_acc + {2'b00, SRC_DATA};
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_c_clr  = 1'b0;
    w_c_inc  = 1'b0;
    w_s_inc  = 1'b0;
    case (r_state)
      S_IDLE: if (START) begin
        w_accept = 1'b1;
        w_c_clr  = 1'b1;
        w_next   = (w_start_mode == MODE_BA) ? S_BA_RD : S_RD;
      end
      S_RD:     w_next = (r_mode == MODE_PR) ? S_PR_WR : S_WR;
      S_WR: begin
        if (w_c_last) w_next = S_FIN;
        else begin w_c_inc = 1'b1; w_next = S_RD; end
      end
      S_PR_WR: begin
        w_s_inc = 1'b1;
        if (w_s_last) begin
          if (w_c_last) w_next = S_FIN;
          else begin w_c_inc = 1'b1; w_next = S_RD; end
        end
      end
      S_BA_RD: begin
        w_s_inc = 1'b1;
        if (w_s_last) w_next = S_BA_ACC;
      end
      S_BA_ACC: w_next = S_BA_WR;
      S_BA_WR: begin
        if (w_c_last) w_next = S_FIN;
        else begin w_c_inc = 1'b1; w_next = S_BA_RD; end
      end
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sx = w_cx;
    w_sy = w_cy;
    w_dx = w_cx;
    w_dy = w_cy;
    case (r_mode)
      MODE_NN: begin w_sx = {1'b0, w_cx[9:1]}; w_sy = {1'b0, w_cy[9:1]}; end
      MODE_PR: begin w_dx = {w_cx[8:0], w_bx}; w_dy = {w_cy[8:0], w_by}; end
      MODE_DC: begin w_sx = {w_cx[8:0], 1'b0}; w_sy = {w_cy[8:0], 1'b0}; end
      MODE_BA: begin w_sx = {w_cx[8:0], w_bx}; w_sy = {w_cy[8:0], w_by}; end
      default: ;
    endcase
  end

  assign w_src_addr = SRC_AW'(32'(w_sy) * SRC_W + 32'(w_sx));
  assign w_dst_addr = DST_AW'(32'(w_dy) * 32'(r_out_w) + 32'(w_dx));
  assign w_avg      = PIX_W'((r_acc + (PIX_W+2)'(2)) >> 2);

  always_comb begin
    w_dst_data = '0;
    case (r_state)
      S_WR:    w_dst_data = SRC_DATA;
      S_PR_WR: w_dst_data = w_sub_first ? SRC_DATA : r_pix;
      S_BA_WR: w_dst_data = w_avg;
      default: ;
    endcase
  end

  assign SRC_RD_EN = (r_state == S_RD) || (r_state == S_BA_RD);
  assign DST_WE    = (r_state == S_WR) || (r_state == S_PR_WR) || (r_state == S_BA_WR);
  assign SRC_ADDR  = SRC_RD_EN ? w_src_addr : '0;
  assign DST_ADDR  = DST_WE ? w_dst_addr : '0;
  assign DST_DATA  = w_dst_data;
  assign OUT_W     = r_out_w;
  assign OUT_H     = r_out_h;
  assign BUSY      = (r_state != S_IDLE) && (r_state != S_FIN);
  assign DONE      = (r_state == S_FIN);

endmodule

`default_nettype wire

// File: tb/tb_zoom_engine.sv
// tb_zoom_engine: reduced-size image, reference model of every scaling mode,
// per-cycle write/timing comparison against the model.
`default_nettype none

module tb_zoom_engine;

  localparam int W   = 8;
  localparam int H   = 6;
  localparam int PW  = 8;
  localparam int SAW = 6;
  localparam int DAW = 8;

  logic           CLK = 1'b0;
  logic           RESET = 1'b1;
  logic           START = 1'b0;
  logic [1:0]     ALGORITHM = 2'd0;
  logic [1:0]     IMAGE_STATE = 2'd0;
  logic           SRC_RD_EN;
  logic [SAW-1:0] SRC_ADDR;
  logic [PW-1:0]  SRC_DATA = '0;
  logic           DST_WE;
  logic [DAW-1:0] DST_ADDR;
  logic [PW-1:0]  DST_DATA;
  logic [9:0]     OUT_W, OUT_H;
  logic           BUSY, DONE;

  always #5 CLK = ~CLK;

  zoom_engine #(.SRC_W(W), .SRC_H(H), .PIX_W(PW), .SRC_AW(SAW), .DST_AW(DAW)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ALGORITHM(ALGORITHM),
    .IMAGE_STATE(IMAGE_STATE), .SRC_RD_EN(SRC_RD_EN), .SRC_ADDR(SRC_ADDR),
    .SRC_DATA(SRC_DATA), .DST_WE(DST_WE), .DST_ADDR(DST_ADDR), .DST_DATA(DST_DATA),
    .OUT_W(OUT_W), .OUT_H(OUT_H), .BUSY(BUSY), .DONE(DONE)
  );

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  int   checks = 0;
  int   failures = 0;
  int   src_img [W*H];
  int   dst_img [4*W*H];
  int   nn_dump [4*W*H];
  wr_t  exp_q[$];
  int   log_addr[$];
  int   edge_n = 0;
  int   t0 = 0;
  int   exp_done = 0;
  int   exp_ow = 0;
  int   exp_oh = 0;
  int   last_done_rel = 0;
  bit   active = 1'b0;
  bit   done_seen = 1'b0;
  wr_t  e_cur;
  int   rel;

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Synchronous-read source memory.
  always @(posedge CLK) begin
    edge_n++;
    if (SRC_RD_EN) SRC_DATA <= PW'(src_img[SRC_ADDR]);
  end

  always @(negedge CLK) begin
    if (active) begin
      rel = edge_n - t0 + 1;
      chk("rd_wr_exclusive", int'(SRC_RD_EN && DST_WE), 0);
      chk("busy", int'(BUSY), DONE ? 0 : 1);
      if (DST_WE) begin
        dst_img[DST_ADDR] = int'(DST_DATA);
        log_addr.push_back(int'(DST_ADDR));
        if (exp_q.size() == 0) begin
          chk("unexpected_write", int'(DST_ADDR), -1);
        end else begin
          e_cur = exp_q.pop_front();
          checks++;
          if (int'(DST_ADDR) != e_cur.addr || int'(DST_DATA) != e_cur.data || rel != e_cur.cyc) begin
            failures++;
            $display("FAIL write: got addr=%0d data=%0d cyc=%0d expected addr=%0d data=%0d cyc=%0d",
                     DST_ADDR, DST_DATA, rel, e_cur.addr, e_cur.data, e_cur.cyc);
          end
        end
      end
      if (DONE) begin
        done_seen = 1'b1;
        last_done_rel = rel;
        chk("done_cycle", rel, exp_done);
        chk("writes_pending_at_done", exp_q.size(), 0);
      end
    end
  end

  function automatic int src(input int x, input int y);
    return src_img[y*W + x];
  endfunction

  task automatic build_model(input int alg, input int st);
    int  mode, ow, oh, k, d;
    wr_t e;
    exp_q.delete();
    mode = 0;
    if (st == 1) mode = (alg == 1) ? 2 : 1;
    else if (st == 2) mode = (alg == 3) ? 4 : 3;
    if (mode == 1 || mode == 2) begin ow = 2*W; oh = 2*H; end
    else if (mode >= 3) begin ow = W/2; oh = H/2; end
    else begin ow = W; oh = H; end
    exp_ow = ow;
    exp_oh = oh;
    k = 0;
    if (mode == 2) begin
      for (int sy = 0; sy < H; sy++)
        for (int sx = 0; sx < W; sx++) begin
          for (int b = 0; b < 4; b++) begin
            e.cyc  = 5*k + 2 + b;
            e.addr = (2*sy + b/2) * ow + 2*sx + b%2;
            e.data = src(sx, sy);
            exp_q.push_back(e);
          end
          k++;
        end
      exp_done = 5*W*H + 1;
    end else begin
      for (int y = 0; y < oh; y++)
        for (int x = 0; x < ow; x++) begin
          case (mode)
            1:       d = src(x/2, y/2);
            3:       d = src(2*x, 2*y);
            4:       d = (src(2*x, 2*y) + src(2*x+1, 2*y) + src(2*x, 2*y+1) + src(2*x+1, 2*y+1) + 2) / 4;
            default: d = src(x, y);
          endcase
          e.cyc  = (mode == 4) ? 6*k + 6 : 2*k + 2;
          e.addr = y*ow + x;
          e.data = d;
          exp_q.push_back(e);
          k++;
        end
      exp_done = ((mode == 4) ? 6 : 2) * ow * oh + 1;
    end
  endtask

  task automatic start_op(input int alg, input int st);
    build_model(alg, st);
    foreach (dst_img[i]) dst_img[i] = -1;
    log_addr.delete();
    done_seen = 1'b0;
    @(negedge CLK);
    ALGORITHM = 2'(alg);
    IMAGE_STATE = 2'(st);
    START = 1'b1;
    @(posedge CLK);
    #1;
    t0 = edge_n;
    START = 1'b0;
    active = 1'b1;
    chk("out_w", int'(OUT_W), exp_ow);
    chk("out_h", int'(OUT_H), exp_oh);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_seen && n < exp_done + 50) begin
      @(posedge CLK);
      n++;
    end
    if (!done_seen) chk("done_timeout", 0, 1);
    active = 1'b0;
    @(negedge CLK);
    chk("idle_after_done", int'({BUSY, DONE}), 0);
  endtask

  task automatic run_op(input int alg, input int st);
    start_op(alg, st);
    wait_done();
  endtask

  task automatic fill_xy();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) src_img[y*W + x] = (x + y) & 255;
  endtask

  task automatic fill_rand();
    foreach (src_img[i]) src_img[i] = int'($urandom_range(0, 255));
  endtask

  initial begin
    int mism, n, wes;

    repeat (3) @(negedge CLK);
    chk("rst_ctrl", int'({SRC_RD_EN, DST_WE, BUSY, DONE}), 0);
    chk("rst_bus", int'(SRC_ADDR) + int'(DST_ADDR) + int'(DST_DATA), 0);
    chk("rst_out_w", int'(OUT_W), 0);
    chk("rst_out_h", int'(OUT_H), 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // COPY, algorithm code ignored at default scale
    fill_xy();
    run_op(3, 0);
    chk("copy_addr_w1", dst_img[W+1], 2);
    chk("copy_done_edges", last_done_rel, 97);
    chk("copy_writes", log_addr.size(), 48);

    fill_xy();
    run_op(0, 1);
    foreach (nn_dump[i]) nn_dump[i] = dst_img[i];
    chk("nn_dst_3_5", dst_img[83], 3);
    chk("nn_done_edges", last_done_rel, 385);
    chk("nn_writes", log_addr.size(), 192);

    run_op(1, 1);
    chk("pr_addr0", (log_addr.size() > 3) ? log_addr[0] : -1, 0);
    chk("pr_addr1", (log_addr.size() > 3) ? log_addr[1] : -1, 1);
    chk("pr_addr2", (log_addr.size() > 3) ? log_addr[2] : -1, 16);
    chk("pr_addr3", (log_addr.size() > 3) ? log_addr[3] : -1, 17);
    chk("pr_done_edges", last_done_rel, 241);
    mism = 0;
    foreach (nn_dump[i]) if (nn_dump[i] != dst_img[i]) mism++;
    chk("pr_vs_nn_dump", mism, 0);

    fill_rand();
    src_img[0] = 1; src_img[1] = 2; src_img[W] = 3; src_img[W+1] = 5;
    run_op(3, 2);
    chk("ba_block", dst_img[0], 3);
    chk("ba_writes", log_addr.size(), 12);
    chk("ba_done_edges", last_done_rel, 73);

    foreach (src_img[i]) src_img[i] = 255;
    run_op(3, 2);
    mism = 0;
    for (int i = 0; i < 12; i++) if (dst_img[i] != 255) mism++;
    chk("ba_saturated", mism, 0);

    // reduce with a non-BA algorithm resolves to decimation
    fill_rand();
    run_op(0, 2);
    chk("dc_dst_1_1", dst_img[W/2 + 1], src_img[2*W + 2]);
    chk("dc_out_w", int'(OUT_W), 4);
    chk("dc_out_h", int'(OUT_H), 3);

    // START and input changes while busy are ignored
    fill_rand();
    start_op(2, 0);
    repeat (3) @(negedge CLK);
    START = 1'b1;
    ALGORITHM = 2'd1;
    IMAGE_STATE = 2'd1;
    @(negedge CLK);
    START = 1'b0;
    wait_done();

    for (int i = 0; i < 6; i++) begin
      fill_rand();
      run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // abort mid-operation
    fill_rand();
    start_op(0, 1);
    n = 0;
    while (log_addr.size() < 100 && n < 1000) begin
      @(posedge CLK);
      n++;
    end
    chk("abort_progress", (log_addr.size() >= 100) ? 1 : 0, 1);
    @(negedge CLK);
    active = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    chk("abort_ctrl", int'({SRC_RD_EN, DST_WE, BUSY, DONE}), 0);
    chk("abort_bus", int'(SRC_ADDR) + int'(DST_ADDR) + int'(DST_DATA), 0);
    chk("abort_out", int'(OUT_W) + int'(OUT_H), 0);
    RESET = 1'b0;
    wes = 0;
    repeat (20) begin
      @(negedge CLK);
      wes += int'(DST_WE);
    end
    chk("abort_no_writes", wes, 0);
    exp_q.delete();
    fill_rand();
    run_op(3, 2);
    chk("post_abort_done", last_done_rel, 73);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/zoom_engine.md
Name: zoom_engine

Overview:
- Executes the scaling operation selected by the zoom selection logic.
- On a START pulse it latches ALGORITHM and IMAGE_STATE, reads the source image from a synchronous-read source memory, and writes the scaled image row-major into the destination frame buffer.
- It consumes the algorithm/state encoding that the selection side produces: 0 NN, 1 PR, 2 DC, 3 BA; states 0 DEFAULT, 1 ENLARGED, 2 REDUCED.

Parameters:
- SRC_W, 160, source image width in pixels
- SRC_H, 120, source image height in pixels
- PIX_W, 8, pixel width in bits (grayscale)
- SRC_AW, 15, source address width; must satisfy 2**SRC_AW >= SRC_W*SRC_H
- DST_AW, 17, destination address width; must satisfy 2**DST_AW >= 4*SRC_W*SRC_H

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- START  in  1  one-cycle request to begin an operation
- ALGORITHM  in  2  algorithm code, sampled only on an accepted START
- IMAGE_STATE  in  2  scale code, sampled only on an accepted START
- SRC_RD_EN  out  1  source read strobe
- SRC_ADDR  out  SRC_AW  source address, y*SRC_W+x
- SRC_DATA  in  PIX_W  source read data, valid exactly 1 cycle after SRC_RD_EN
- DST_WE  out  1  destination write strobe
- DST_ADDR  out  DST_AW  destination address, y*OUT_W+x
- DST_DATA  out  PIX_W  destination write data
- OUT_W  out  10  output width of the last accepted operation
- OUT_H  out  10  output height of the last accepted operation
- BUSY  out  1  high while an operation is running
- DONE  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0; FSM in IDLE. Assertion at any time, including mid-operation, aborts immediately; no further writes occur.
- START acceptance:
  - START is accepted only in IDLE. START while BUSY is ignored.
  - On the accepting edge: ALGORITHM/IMAGE_STATE are latched, OUT_W/OUT_H are updated, BUSY goes to 1.
  - Input changes while BUSY have no effect.
- Effective mode, resolved from the latched values:
  - IMAGE_STATE 0 or 3: COPY; OUT = SRC_W x SRC_H; dst(x,y) = src(x,y).
  - IMAGE_STATE 1 with ALG NN, DC or BA: NN; OUT = 2W x 2H; dst(x,y) = src(x>>1, y>>1); destination-major traversal.
  - IMAGE_STATE 1 with ALG PR: PR; same image as NN. Traversal is source-major: each source pixel is read once and written to dst (2x,2y), (2x+1,2y), (2x,2y+1), (2x+1,2y+1), in that order.
  - IMAGE_STATE 2 with ALG DC, NN or PR: DC; OUT = W/2 x H/2; dst(x,y) = src(2x,2y).
  - IMAGE_STATE 2 with ALG BA: BA; dst(x,y) = (s00+s10+s01+s11+2)>>2, using a PIX_W+2-bit accumulator. Reads are issued in the order s00, s10, s01, s11.
- FSM states: IDLE, RD, WR, PR_WR (4 beats), BA_RD (4 beats), BA_ACC, BA_WR, FIN.
  - COPY/NN/DC: RD then WR per destination pixel, 2 cycles per pixel. DST_WE asserts in the cycle after SRC_RD_EN, with DST_DATA = SRC_DATA.
  - PR: RD, then 4 write cycles; 5 cycles per source pixel.
  - BA: 4 read cycles, then ACC, then WR; 6 cycles per destination pixel. The accumulator is pipelined one cycle behind the reads.
- No idle cycles between pixels. The x counter wraps at its limit and increments y; the final pixel enters FIN.
- FIN: DONE=1 and BUSY=0 for one cycle, then IDLE. A START in the FIN cycle is ignored; START is accepted from IDLE only.
- Operation cycle counts, START edge to DONE cycle = count+1, at default parameters:
  - COPY 38400
  - NN 153600
  - PR 96000
  - DC 9600
  - BA 28800
- Destination addresses are a compact row-major layout using OUT_W as stride.
- SRC_RD_EN and DST_WE are never both 1 in the same cycle, except during COPY/NN/DC steady state, where a write and the next read overlap only if the pipelined option is enabled. That option is not implemented: strict alternation is required.

Decomposition:
- Package zoom_pkg holds:
  - algorithm codes ALG_NN/PR/DC/BA
  - state codes ST_DEFAULT/ENLARGED/REDUCED
  - effective-mode enum MODE_COPY/NN/PR/DC/BA
  - FSM state enum
- Sub-module zoom_xy_counter: nested x/y counter with run-time limits, clear, inc, and a last-pixel flag. It is instantiated twice, once for destination coordinates and once for the BA/PR sub-pixel offset.

Test Plan:
- COPY: src(x,y) = (x+y)&0xFF, ALG=BA, IMAGE_STATE=0 -> 19200 writes; addr 161 = 2; DONE exactly 38401 edges after START; OUT_W/H = 160/120.
- NN: IMAGE_STATE=1, ALG=NN -> 76800 writes; dst(3,5) at addr 5*320+3 = 1603 equals src(1,2) = 3; DONE after 153601 edges.
- PR: IMAGE_STATE=1, ALG=PR -> first four writes go to addresses 0, 1, 320, 321, all with src(0,0); a full dump matches the NN run byte-for-byte.
- BA: source 2x2 block values 1, 2, 3, 5 -> dst(0,0) = 3. An all-255 image -> every output is 255, with no accumulator overflow. 4800 writes total.
- Mismatch: IMAGE_STATE=2, ALG=NN -> DC used; dst(1,1) = src(2,2); OUT_W/H = 80/60.
- Control: START pulsed while BUSY with different ALG -> ignored and output unchanged. RESET at pixel 1000 -> all outputs 0 next cycle, no further DST_WE; a new START runs to a normal DONE.
